ifu_pc: RTL and testbench

Program-counter register and instruction-fetch sequencer for the single-cycle NPC core. Holds the architectural PC, fetches one instruction at a time from instruction memory over a valid/ready request and valid response handshake, and presents the instruction to decode/execute. It consumes the 2-bit `pc_src` select produced by the next-PC decision logic and computes the next PC when execute signals commit.

---
 rtl/ifu_pc.sv | 108 ++++++++++
 tb/tb_ifu_pc.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_pc.sv
`default_nettype none
// ============================================================================
// ifu_pc : architectural PC register and one-at-a-time instruction fetch FSM
// Rev 1.0 - initial release
// ============================================================================
module ifu_pc #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] csr_pc,
  input  logic            commit,
  input  logic            halt,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] w_dnpc;
  logic [XLEN-1:0] w_rs1_sum;
  logic            w_pc_load;
  logic            w_inst_load;

  assign snpc      = r_pc + XLEN'(4);
  assign w_rs1_sum = rs1_data + imm;

  // Dynamic next PC; all sums wrap modulo 2^XLEN, jalr target has bit 0 cleared
  always_comb begin
    w_dnpc = snpc;
    case (pc_src)
      2'b00:   w_dnpc = snpc;
      2'b01:   w_dnpc = r_pc + imm;
      2'b10:   w_dnpc = w_rs1_sum & ~XLEN'(1);
      default: w_dnpc = csr_pc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_inst_load = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_nxt = S_EXEC;
          w_inst_load = 1'b1;
        end
      end
      S_EXEC: begin
        // halt wins over a simultaneous commit and leaves the PC untouched
        if (halt) begin
          w_state_nxt = S_HALT;
        end else if (commit) begin
          w_state_nxt = S_REQ;
          w_pc_load   = 1'b1;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_load)   r_pc   <= w_dnpc;
      if (w_inst_load) r_inst <= imem_rsp_data;
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign inst_valid     = (r_state == S_EXEC);
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign inst           = r_inst;

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc.sv
`default_nettype none
// ============================================================================
// tb_ifu_pc : scoreboard bench for ifu_pc, expected fetch addresses queued at
// commit and popped when the fetch request is accepted
// Rev 1.0 - initial release
// ============================================================================
module tb_ifu_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] imm, rs1_data, csr_pc;
  logic        commit, halt;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst, pc, snpc;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];

  ifu_pc #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .imm(imm), .rs1_data(rs1_data),
    .csr_pc(csr_pc), .commit(commit), .halt(halt),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid), .inst(inst),
    .pc(pc), .snpc(snpc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one fetch: waits (bounded) for a request, accepts it, answers after
  // rsp_dly WAIT cycles and returns in the EXEC cycle.
  task automatic fetch(input int rsp_dly, input logic [31:0] word,
                       output logic [31:0] addr, output int acc_cyc, output bit ok);
    int n = 0;
    ok = 1'b0; addr = 'x; acc_cyc = 0;
    while (imem_req_valid !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) return;
    end
    addr = imem_addr; acc_cyc = cyc;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (rsp_dly) @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = word;
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    ok = (inst_valid === 1'b1);
  endtask

  task automatic do_commit(input logic [1:0] src, input logic [31:0] i_v,
                           input logic [31:0] r_v, input logic [31:0] c_v, input logic h);
    pc_src = src; imm = i_v; rs1_data = r_v; csr_pc = c_v;
    commit = 1'b1; halt = h;
    @(negedge clk);
    commit = 1'b0; halt = 1'b0;
    imm = $urandom; rs1_data = $urandom; csr_pc = $urandom; pc_src = 2'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pc !== 32'h8000_0000 || imem_addr !== 32'h8000_0000 || snpc !== 32'h8000_0004) begin
      bad++; $display("FAIL reset_pc: pc=%h addr=%h snpc=%h want 80000000/80000000/80000004", pc, imem_addr, snpc);
    end
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      bad++; $display("FAIL reset_out: req=%b iv=%b inst=%h want 0/0/0", imem_req_valid, inst_valid, inst);
    end
    rst = 1'b0;
    exp_q.push_back(32'h8000_0000);
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL idle_cycle: req=%b want 0", imem_req_valid);
    end
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b1) begin
      bad++; $display("FAIL first_req: req=%b want 1", imem_req_valid);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a, e;
    int acc, prev_acc;
    bit ok;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      fetch(0, 32'h0000_0013 + (i << 20), a, acc, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || a !== e) begin
        bad++; $display("FAIL seq_addr[%0d]: got %h ok=%b want %h", i, a, ok, e);
      end
      total++;
      if (inst !== 32'h0000_0013 + (i << 20)) begin
        bad++; $display("FAIL seq_inst[%0d]: got %h want %h", i, inst, 32'h0000_0013 + (i << 20));
      end
      if (i > 0) begin
        total++;
        if (acc - prev_acc !== 3) begin
          bad++; $display("FAIL seq_cpi[%0d]: got %0d cycles want 3", i, acc - prev_acc);
        end
      end
      prev_acc = acc;
      exp_q.push_back(e + 32'd4);
      do_commit(2'b00, $urandom, $urandom, $urandom, 1'b0);
    end
  endtask

  task automatic test_next_pc;
    // {pc_src, imm, rs1_data, csr_pc, target}; queue front is 8000_0010 here
    logic [1:0]  src_t[7] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [31:0] imm_t[7] = '{32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0100, 32'h0000_0044,
                              32'h0000_0700, 32'h0000_0002, 32'h0000_0004};
    logic [31:0] rs1_t[7] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                              32'h5555_5555, 32'h8000_1001, 32'h6666_6666};
    logic [31:0] csr_t[7] = '{32'h7777_7770, 32'h7777_7770, 32'h7777_7770, 32'hFFFF_FFFC,
                              32'h7777_7770, 32'h7777_7770, 32'h8000_0200};
    logic [31:0] tgt_t[7] = '{32'h8000_0000, 32'h8000_0010, 32'h8000_0110, 32'hFFFF_FFFC,
                              32'h0000_0000, 32'h8000_1002, 32'h8000_0200};
    logic [31:0] a, e;
    int acc;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      fetch(0, 32'hA000_0000 + i, a, acc, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || a !== e) begin
        bad++; $display("FAIL npc_addr[%0d]: got %h ok=%b want %h", i, a, ok, e);
      end
      if (e == 32'hFFFF_FFFC) begin
        total++;
        if (snpc !== 32'h0000_0000) begin
          bad++; $display("FAIL snpc_wrap: got %h want 00000000", snpc);
        end
      end
      exp_q.push_back(tgt_t[i]);
      do_commit(src_t[i], imm_t[i], rs1_t[i], csr_t[i], 1'b0);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (imem_req_valid !== 1'b1 || imem_addr !== e) begin
        bad++; $display("FAIL bp_hold[%0d]: req=%b addr=%h want 1/%h", k, imem_req_valid, imem_addr, e);
      end
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        bad++; $display("FAIL bp_wait[%0d]: iv=%b req=%b want 0/0", k, inst_valid, imem_req_valid);
      end
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D;
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    total++;
    if (inst_valid !== 1'b1 || inst !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL bp_rsp: iv=%b inst=%h want 1/cafef00d", inst_valid, inst);
    end
    exp_q.push_back(32'h8000_0204);
    do_commit(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_commit_hold;
    logic [31:0] a, e;
    int acc;
    bit ok;
    fetch(0, 32'h1234_5678, a, acc, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || a !== e) begin
      bad++; $display("FAIL hold_addr: got %h ok=%b want %h", a, ok, e);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (inst_valid !== 1'b1 || pc !== 32'h8000_0204) begin
        bad++; $display("FAIL hold_exec[%0d]: iv=%b pc=%h want 1/80000204", k, inst_valid, pc);
      end
    end
    exp_q.push_back(32'h8000_0224);
    do_commit(2'b01, 32'h0000_0020, 32'h0, 32'h0, 1'b0);
    // stray commit/halt/response while in REQ with ready low
    commit = 1'b1; halt = 1'b1; pc_src = 2'b11; csr_pc = 32'hDEAD_0000;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    commit = 1'b0; halt = 1'b0; imem_rsp_valid = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || pc !== exp_q[0] || inst !== 32'h1234_5678) begin
      bad++; $display("FAIL stray_req: req=%b pc=%h inst=%h want 1/%h/12345678", imem_req_valid, pc, inst, exp_q[0]);
    end
    e = exp_q.pop_front();
    total++;
    if (imem_addr !== e) begin
      bad++; $display("FAIL stray_addr: got %h want %h", imem_addr, e);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    commit = 1'b1; halt = 1'b1;
    repeat (2) @(negedge clk);
    commit = 1'b0; halt = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc !== 32'h8000_0224) begin
      bad++; $display("FAIL stray_wait: iv=%b req=%b pc=%h want 0/0/80000224", inst_valid, imem_req_valid, pc);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BEE_F000;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b1 || inst !== 32'h0BEE_F000) begin
      bad++; $display("FAIL stray_exec: iv=%b inst=%h want 1/0beef000", inst_valid, inst);
    end
    exp_q.push_back(32'h8000_0228);
    do_commit(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_halt;
    logic [31:0] a, e;
    int acc, errs;
    bit ok;
    fetch(1, 32'h0010_0073, a, acc, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || a !== e) begin
      bad++; $display("FAIL halt_addr: got %h ok=%b want %h", a, ok, e);
    end
    do_commit(2'b11, 32'h0, 32'h0, 32'h0000_1234, 1'b1);
    imem_req_ready = 1'b1;
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h8000_0228 ||
          inst !== 32'h0010_0073) errs++;
      if (k == 5) commit = 1'b1;
      @(negedge clk);
    end
    commit = 1'b0; imem_req_ready = 1'b0;
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL halt_stuck: %0d bad cycles (req=%b iv=%b pc=%h) want 0", errs, imem_req_valid, inst_valid, pc);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] a, e;
    int acc;
    bit ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h8000_0000);
    // late response during the IDLE cycle must not be captured
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || inst !== 32'h0 || imem_addr !== exp_q[0]) begin
      bad++; $display("FAIL late_rsp: req=%b inst=%h addr=%h want 1/00000000/80000000", imem_req_valid, inst, imem_addr);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hFEED_0001;
    #2 rst = 1'b1;
    #1;
    total++;
    if (pc !== 32'h8000_0000 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst !== 32'h0) begin
      bad++; $display("FAIL async_rst: pc=%h iv=%b req=%b inst=%h want 80000000/0/0/0", pc, inst_valid, imem_req_valid, inst);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++; $display("FAIL rst_idle: req=%b iv=%b want 0/0", imem_req_valid, inst_valid);
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    fetch(0, 32'h0000_0297, a, acc, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || a !== e || inst !== 32'h0000_0297) begin
      bad++; $display("FAIL refetch: addr=%h ok=%b inst=%h want %h/1/00000297", a, ok, inst, e);
    end
  endtask

  initial begin
    pc_src = 2'b00; imm = '0; rs1_data = '0; csr_pc = '0;
    commit = 1'b0; halt = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_next_pc();
    test_backpressure();
    test_commit_hold();
    test_halt();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
